// File: rtl/box_pkg.sv
// Shared definitions for the player box: play-state encoding, default physics
// constants and position/velocity types reused by renderer and collision logic.
package box_pkg;

    localparam int unsigned DEF_Y_W      = 7;
    localparam int unsigned DEF_V_W      = 5;
    localparam int unsigned DEF_START_Y  = 60;
    localparam int unsigned DEF_FLOOR_Y  = 120;
    localparam int unsigned DEF_GRAVITY  = 1;
    localparam int unsigned DEF_FLAP_V   = 5;
    localparam int unsigned DEF_MAX_FALL = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLYING = 2'd1,
        ST_DEAD   = 2'd2
    } box_state_e;

    typedef logic [DEF_Y_W-1:0]        box_pos_t;
    typedef logic signed [DEF_V_W-1:0] box_vel_t;

endpackage

// File: rtl/box_tap_latch.sv
// Holds a flap request between a tap and the next game tick while flying;
// taps outside flight are dropped, and a tap coincident with a tick is used directly.
module box_tap_latch (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_tap,
    input  logic i_tick,
    input  logic i_en,
    output logic o_flap_pend
);

    logic r_flap_pend;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_flap_pend <= 1'b0;
        end else if (!i_en || i_tick) begin
            r_flap_pend <= 1'b0;
        end else if (i_tap) begin
            r_flap_pend <= 1'b1;
        end
    end

    assign o_flap_pend = r_flap_pend;

endmodule

// File: rtl/box_physics.sv
// Player box position/velocity integrator with IDLE/FLYING/DEAD play state.
// Define BOX_CEILING_KILL_EN to make a ceiling clamp also kill the box.
module box_physics
    import box_pkg::*;
#(
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned V_W      = DEF_V_W,
    parameter int unsigned START_Y  = DEF_START_Y,
    parameter int unsigned FLOOR_Y  = DEF_FLOOR_Y,
    parameter int unsigned GRAVITY  = DEF_GRAVITY,
    parameter int unsigned FLAP_V   = DEF_FLAP_V,
    parameter int unsigned MAX_FALL = DEF_MAX_FALL
) (
    input  logic           game_clk,
    input  logic           resetn,
    input  logic           tick,
    input  logic           tap,
    input  logic           start,
    output logic [Y_W-1:0] y_coordinate,
    output logic [V_W-1:0] velocity,
    output logic [1:0]     state,
    output logic           hit_floor,
    output logic           hit_ceiling
);

    localparam int unsigned CW = ((Y_W > V_W) ? Y_W : V_W) + 2;

    localparam logic signed [CW-1:0] C_ZERO     = '0;
    localparam logic signed [CW-1:0] C_GRAV     = CW'(GRAVITY);
    localparam logic signed [CW-1:0] C_MAXF     = CW'(MAX_FALL);
    localparam logic signed [CW-1:0] C_FLOOR    = CW'(FLOOR_Y);
    localparam logic signed [CW-1:0] C_FLAP_VEL = -$signed(CW'(FLAP_V));

    if (!(START_Y > 0 && START_Y < FLOOR_Y && (FLOOR_Y >> Y_W) == 0)) begin : g_chk_pos
        $error("box_physics: need 0 < START_Y < FLOOR_Y < 2**Y_W");
    end
    if ((FLAP_V >> (V_W - 1)) != 0 || (MAX_FALL >> (V_W - 1)) != 0) begin : g_chk_vel
        $error("box_physics: FLAP_V and MAX_FALL must fit in V_W-1 bits");
    end
    if (GRAVITY < 1) begin : g_chk_grav
        $error("box_physics: GRAVITY must be at least 1");
    end

    box_state_e             r_state, w_state_nx;
    logic [Y_W-1:0]         r_y, w_y_nx;
    logic signed [V_W-1:0]  r_vel, w_vel_nx;
    logic                   r_hit_floor, w_hit_floor_nx;
    logic                   r_hit_ceil, w_hit_ceil_nx;
    logic                   w_flap_pend;
    logic                   w_flying;
    logic signed [CW-1:0]   w_vel_ext, w_vel_grav, w_vel_new, w_y_next;

    assign w_flying = (r_state == ST_FLYING);

    box_tap_latch u_tap_latch (
        .i_clk       (game_clk),
        .i_resetn    (resetn),
        .i_tap       (tap),
        .i_tick      (tick),
        .i_en        (w_flying),
        .o_flap_pend (w_flap_pend)
    );

    // Candidate velocity and position, evaluated wide enough that nothing wraps.
    assign w_vel_ext = {{(CW - V_W){r_vel[V_W-1]}}, r_vel};

    always_comb begin
        w_vel_grav = w_vel_ext + C_GRAV;
        if (w_flap_pend || tap) begin
            w_vel_new = C_FLAP_VEL;
        end else if (w_vel_grav > C_MAXF) begin
            w_vel_new = C_MAXF;
        end else begin
            w_vel_new = w_vel_grav;
        end
        w_y_next = $signed({{(CW - Y_W){1'b0}}, r_y}) + w_vel_new;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_y_nx         = r_y;
        w_vel_nx       = r_vel;
        w_hit_floor_nx = r_hit_floor;
        w_hit_ceil_nx  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start || tap) begin
                    w_state_nx = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (tick) begin
                    if (w_y_next <= C_ZERO) begin
                        w_y_nx        = '0;
                        w_vel_nx      = '0;
                        w_hit_ceil_nx = 1'b1;
`ifdef BOX_CEILING_KILL_EN
                        w_state_nx    = ST_DEAD;
`endif
                    end else if (w_y_next >= C_FLOOR) begin
                        w_y_nx         = Y_W'(FLOOR_Y);
                        w_vel_nx       = '0;
                        w_state_nx     = ST_DEAD;
                        w_hit_floor_nx = 1'b1;
                    end else begin
                        w_y_nx   = Y_W'(w_y_next);
                        w_vel_nx = V_W'(w_vel_new);
                    end
                end
            end
            ST_DEAD: begin
                if (start) begin
                    w_state_nx     = ST_FLYING;
                    w_y_nx         = Y_W'(START_Y);
                    w_vel_nx       = '0;
                    w_hit_floor_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge game_clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_y         <= Y_W'(START_Y);
            r_vel       <= '0;
            r_hit_floor <= 1'b0;
            r_hit_ceil  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_y         <= w_y_nx;
            r_vel       <= w_vel_nx;
            r_hit_floor <= w_hit_floor_nx;
            r_hit_ceil  <= w_hit_ceil_nx;
        end
    end

    assign y_coordinate = r_y;
    assign velocity     = r_vel;
    assign state        = r_state;
    assign hit_floor    = r_hit_floor;
    assign hit_ceiling  = r_hit_ceil;

endmodule

// File: tb/tb_box_physics.sv
// Scoreboard bench for box_physics: each stimulus cycle queues its expected
// registered outputs; a negedge monitor pops and compares them.
module tb_box_physics;

    localparam int S_IDLE = 0;
    localparam int S_FLY  = 1;
    localparam int S_DEAD = 2;
`ifdef BOX_CEILING_KILL_EN
    localparam int S_CEIL = S_DEAD;
`else
    localparam int S_CEIL = S_FLY;
`endif

    logic       game_clk;
    logic       resetn;
    logic       tick;
    logic       tap;
    logic       start;
    logic [6:0] y_coordinate;
    logic [4:0] velocity;
    logic [1:0] state;
    logic       hit_floor;
    logic       hit_ceiling;

    box_physics dut (
        .game_clk     (game_clk),
        .resetn       (resetn),
        .tick         (tick),
        .tap          (tap),
        .start        (start),
        .y_coordinate (y_coordinate),
        .velocity     (velocity),
        .state        (state),
        .hit_floor    (hit_floor),
        .hit_ceiling  (hit_ceiling)
    );

    typedef struct {
        string nm;
        int    y;
        int    v;
        int    st;
        int    hf;
        int    hc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    task automatic chk(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge game_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "y",           int'(y_coordinate),      e.y);
            chk(e.nm, "velocity",    int'($signed(velocity)), e.v);
            chk(e.nm, "state",       int'(state),             e.st);
            chk(e.nm, "hit_floor",   int'(hit_floor),         e.hf);
            chk(e.nm, "hit_ceiling", int'(hit_ceiling),       e.hc);
        end
    end

    task automatic step(input string nm, input logic tk, input logic tp, input logic st,
                        input logic rn, input int ey, input int ev, input int es,
                        input int ehf, input int ehc);
        exp_t e;
        @(negedge game_clk);
        tick   = tk;
        tap    = tp;
        start  = st;
        resetn = rn;
        @(posedge game_clk);
        #1;
        e.nm = nm; e.y = ey; e.v = ev; e.st = es; e.hf = ehf; e.hc = ehc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sat_y [10];
        int sat_v [10];
        sat_y = '{54, 52, 51, 51, 52, 54, 57, 61, 65, 69};
        sat_v = '{-3, -2, -1,  0,  1,  2,  3,  4,  4,  4};

        resetn = 1'b0;
        tick   = 1'b0;
        tap    = 1'b0;
        start  = 1'b0;

        step("rst",           0, 0, 0, 0, 60,  0, S_IDLE, 0, 0);
        step("idle_tick",     1, 0, 0, 1, 60,  0, S_IDLE, 0, 0);
        step("start_no_phys", 1, 0, 1, 1, 60,  0, S_FLY,  0, 0);
        step("grav1",         1, 0, 0, 1, 61,  1, S_FLY,  0, 0);
        step("grav2",         1, 0, 0, 1, 63,  2, S_FLY,  0, 0);
        step("grav3",         1, 0, 0, 1, 66,  3, S_FLY,  0, 0);
        step("tap_store",     0, 1, 0, 1, 66,  3, S_FLY,  0, 0);
        step("tap_wait",      0, 0, 0, 1, 66,  3, S_FLY,  0, 0);
        step("flap",          1, 0, 0, 1, 61, -5, S_FLY,  0, 0);
        step("after_flap",    1, 0, 0, 1, 57, -4, S_FLY,  0, 0);
        for (int i = 0; i < 10; i++)
            step("sat", 1, 0, 0, 1, sat_y[i], sat_v[i], S_FLY, 0, 0);
        step("start_in_fly",  0, 0, 1, 1, 69,  4, S_FLY,  0, 0);
        step("tap_on_tick",   1, 1, 0, 1, 64, -5, S_FLY,  0, 0);
        step("no_stale",      1, 0, 0, 1, 60, -4, S_FLY,  0, 0);
        for (int k = 1; k <= 10; k++)
            step("climb", 1, 1, 0, 1, 60 - 5 * k, -5, S_FLY, 0, 0);
        step("coast1",        1, 0, 0, 1,  6, -4, S_FLY,  0, 0);
        step("coast2",        1, 0, 0, 1,  3, -3, S_FLY,  0, 0);
        step("ceil",          1, 1, 0, 1,  0,  0, S_CEIL, 0, 1);
        step("ceil_end",      0, 0, 0, 1,  0,  0, S_CEIL, 0, 0);
`ifdef BOX_CEILING_KILL_EN
        step("post_ceil",     1, 0, 0, 1,  0,  0, S_DEAD, 0, 0);
`else
        step("post_ceil",     1, 0, 0, 1,  1,  1, S_FLY,  0, 0);
`endif
        step("rst2",          0, 0, 0, 0, 60,  0, S_IDLE, 0, 0);
        step("start_tap",     0, 1, 0, 1, 60,  0, S_FLY,  0, 0);
        step("no_start_flap", 1, 0, 0, 1, 61,  1, S_FLY,  0, 0);
        step("fall2",         1, 0, 0, 1, 63,  2, S_FLY,  0, 0);
        step("fall3",         1, 0, 0, 1, 66,  3, S_FLY,  0, 0);
        step("fall4",         1, 0, 0, 1, 70,  4, S_FLY,  0, 0);
        for (int k = 1; k <= 5; k++)
            step("fall_to_90", 1, 0, 0, 1, 70 + 4 * k, 4, S_FLY, 0, 0);
        step("rst_mid",       1, 1, 0, 0, 60,  0, S_IDLE, 0, 0);
        step("restart1",      0, 0, 1, 1, 60,  0, S_FLY,  0, 0);
        step("latch_clear",   1, 0, 0, 1, 61,  1, S_FLY,  0, 0);
        step("drop2",         1, 0, 0, 1, 63,  2, S_FLY,  0, 0);
        step("drop3",         1, 0, 0, 1, 66,  3, S_FLY,  0, 0);
        step("drop4",         1, 0, 0, 1, 70,  4, S_FLY,  0, 0);
        for (int k = 1; k <= 12; k++)
            step("drop_to_118", 1, 0, 0, 1, 70 + 4 * k, 4, S_FLY, 0, 0);
        step("floor",         1, 0, 0, 1, 120, 0, S_DEAD, 1, 0);
        step("dead_tick_tap", 1, 1, 0, 1, 120, 0, S_DEAD, 1, 0);
        step("dead_tap",      0, 1, 0, 1, 120, 0, S_DEAD, 1, 0);
        step("restart2",      0, 0, 1, 1, 60,  0, S_FLY,  0, 0);
        step("post_restart",  1, 0, 0, 1, 61,  1, S_FLY,  0, 0);

        @(negedge game_clk);
        tick = 1'b0;
        tap  = 1'b0;
        #1;
        chk("end", "pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
